// File: rtl/muladd_seq_if.sv
// Stream-in / result-out handshake bundle for the MULADD dot-product sequencer.
// The slave view belongs to the sequencer; the master view belongs to whoever
// feeds operand pairs and collects results.
interface muladd_seq_if #(
  parameter int CNT_W = 5
);
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_a;
  logic [7:0]       s_b;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [19:0]      m_result;
  logic [CNT_W-1:0] m_count;
  logic             m_trunc;

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_result, m_count, m_trunc
  );

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_result, m_count, m_trunc
  );
endinterface

// File: rtl/muladd_seq.sv
// Sequencer driving a MULADD BEL (ACC mode, Q = accumulator) as a dot-product
// engine: clear the accumulator, stream operand pairs into A/B, let the last
// product land, then capture Q and hold it until the consumer takes it.
module muladd_seq #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic        UserCLK,
  input  logic        resetn,
  muladd_seq_if.slave bus,
  output logic [7:0]  mac_A,
  output logic [7:0]  mac_B,
  output logic [19:0] mac_C,
  output logic        mac_clr,
  input  logic [19:0] mac_Q
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    FLUSH,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_LEN);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             at_limit;
  logic             accept;

  assign count_next = count + CNT_W'(1);
  assign at_limit   = (count_next == LIMIT_CNT);
  assign accept     = bus.s_valid && bus.s_ready;

  // The accumulator never needs a C term in this mode.
  assign mac_C = '0;

  // Control FSM; every output it owns is registered, and A/B fall back to zero
  // whenever no pair is being fed because the accumulator adds every cycle.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state        <= IDLE;
      count        <= '0;
      mac_A        <= '0;
      mac_B        <= '0;
      mac_clr      <= 1'b0;
      bus.s_ready  <= 1'b0;
      bus.m_valid  <= 1'b0;
      bus.m_result <= '0;
      bus.m_count  <= '0;
      bus.m_trunc  <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          mac_A <= '0;
          mac_B <= '0;
          if (bus.s_valid) begin
            state   <= CLEAR;
            mac_clr <= 1'b1;
          end
        end
        CLEAR: begin
          mac_A       <= '0;
          mac_B       <= '0;
          count       <= '0;
          bus.s_ready <= 1'b1;
          state       <= ACCUM;
        end
        ACCUM: begin
          if (accept) begin
            mac_A       <= bus.s_a;
            mac_B       <= bus.s_b;
            count       <= count_next;
            bus.m_trunc <= at_limit && !bus.s_last;
            if (bus.s_last || at_limit) begin
              bus.s_ready <= 1'b0;
              state       <= FLUSH;
            end
          end else begin
            mac_A <= '0;
            mac_B <= '0;
          end
        end
        FLUSH: begin
          mac_A <= '0;
          mac_B <= '0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          bus.m_result <= mac_Q;
          bus.m_count  <= count;
          bus.m_valid  <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muladd_seq.sv
// Self-checking bench for muladd_seq with a behavioural MULADD accumulator
// model closing the loop on mac_A/mac_B/mac_clr -> mac_Q.
module tb_muladd_seq;

  logic        UserCLK = 1'b0;
  logic        resetn;
  logic [7:0]  mac_A;
  logic [7:0]  mac_B;
  logic [19:0] mac_C;
  logic        mac_clr;
  logic [19:0] mac_Q;
  logic [19:0] acc = 20'hABCDE;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  typedef struct packed {
    logic [4:0]       n;
    logic [15:0][7:0] a;
    logic [15:0][7:0] b;
    logic             use_last;
    logic [4:0]       gap_before;
    logic [3:0]       gap_len;
    logic [3:0]       ready_delay;
    logic [19:0]      exp_result;
    logic [4:0]       exp_count;
    logic             exp_trunc;
  } vec_t;

  vec_t vecs [6];
  vec_t rst_vec;

  muladd_seq_if #(.CNT_W(5)) bus ();

  muladd_seq #(.MAX_LEN(16), .CNT_W(5)) dut (
    .UserCLK (UserCLK),
    .resetn  (resetn),
    .bus     (bus.slave),
    .mac_A   (mac_A),
    .mac_B   (mac_B),
    .mac_C   (mac_C),
    .mac_clr (mac_clr),
    .mac_Q   (mac_Q)
  );

  // Free-running clock and edge counter used for latency checks.
  always #5 UserCLK = ~UserCLK;
  always @(posedge UserCLK) cyc <= cyc + 1;

  // MULADD in ACC mode: Q is the accumulator, clr wins over the add.
  always @(posedge UserCLK) begin
    if (mac_clr) acc <= '0;
    else         acc <= acc + 20'(mac_A) * 20'(mac_B);
  end
  assign mac_Q = acc;

  // Hard stop in case the DUT wedges somewhere a bounded wait cannot catch.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last, output int edge_no);
    int   budget;
    logic accepted;
    budget   = 0;
    accepted = 1'b0;
    edge_no  = -1;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    while (!accepted && budget < 20) begin
      @(negedge UserCLK);
      accepted = bus.s_ready;
      @(posedge UserCLK);
      #1;
      budget++;
    end
    if (accepted) edge_no = cyc;
    else checkOutput("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int last_edge;
    int waited;
    last_edge = -1;
    for (int i = 0; i < int'(v.n); i++) begin
      if (v.gap_len != 0 && i == int'(v.gap_before)) begin
        bus.s_valid = 1'b0;
        repeat (int'(v.gap_len)) @(posedge UserCLK);
        #1;
      end
      send_pair(v.a[i], v.b[i], v.use_last && (i == int'(v.n) - 1), last_edge);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;

    @(negedge UserCLK);
    checkOutput({tag, ".s_ready_after_last"}, 32'(bus.s_ready), 32'd0);
    waited = 0;
    while (!bus.m_valid && waited < 10) begin
      @(negedge UserCLK);
      waited++;
    end
    checkOutput({tag, ".m_valid_seen"}, 32'(bus.m_valid), 32'd1);
    checkOutput({tag, ".latency"}, 32'(cyc - last_edge), 32'd2);
    checkOutput({tag, ".m_result"}, 32'(bus.m_result), 32'(v.exp_result));
    checkOutput({tag, ".m_count"}, 32'(bus.m_count), 32'(v.exp_count));
    checkOutput({tag, ".m_trunc"}, 32'(bus.m_trunc), 32'(v.exp_trunc));

    for (int k = 0; k < int'(v.ready_delay); k++) begin
      @(negedge UserCLK);
      checkOutput({tag, ".valid_held"}, 32'(bus.m_valid), 32'd1);
      checkOutput({tag, ".result_held"}, 32'(bus.m_result), 32'(v.exp_result));
    end

    bus.m_ready = 1'b1;
    @(posedge UserCLK);
    #1;
    bus.m_ready = 1'b0;
    checkOutput({tag, ".single_handshake"}, 32'(bus.m_valid), 32'd0);
  endtask

  initial begin
    int dummy_edge;

    // Build the directed vector table with hand-computed sums.
    for (int k = 0; k < 6; k++) vecs[k] = '0;

    vecs[0].n = 5'd3; vecs[0].use_last = 1'b1;
    vecs[0].a[0] = 8'd3; vecs[0].b[0] = 8'd4;
    vecs[0].a[1] = 8'd5; vecs[0].b[1] = 8'd6;
    vecs[0].a[2] = 8'd7; vecs[0].b[2] = 8'd8;
    vecs[0].exp_result = 20'd98; vecs[0].exp_count = 5'd3; vecs[0].exp_trunc = 1'b0;

    vecs[1].n = 5'd16; vecs[1].use_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs[1].a[i] = 8'd255; vecs[1].b[i] = 8'd255;
    end
    vecs[1].exp_result = 20'hFE010; vecs[1].exp_count = 5'd16; vecs[1].exp_trunc = 1'b1;

    vecs[2].n = 5'd2; vecs[2].use_last = 1'b1;
    vecs[2].a[0] = 8'd10; vecs[2].b[0] = 8'd10;
    vecs[2].a[1] = 8'd2;  vecs[2].b[1] = 8'd3;
    vecs[2].gap_before = 5'd1; vecs[2].gap_len = 4'd3; vecs[2].ready_delay = 4'd5;
    vecs[2].exp_result = 20'd106; vecs[2].exp_count = 5'd2; vecs[2].exp_trunc = 1'b0;

    vecs[3].n = 5'd1; vecs[3].use_last = 1'b1;
    vecs[3].a[0] = 8'd0; vecs[3].b[0] = 8'd9;
    vecs[3].exp_result = 20'd0; vecs[3].exp_count = 5'd1; vecs[3].exp_trunc = 1'b0;

    vecs[4].n = 5'd1; vecs[4].use_last = 1'b1;
    vecs[4].a[0] = 8'd1; vecs[4].b[0] = 8'd1;
    vecs[4].exp_result = 20'd1; vecs[4].exp_count = 5'd1; vecs[4].exp_trunc = 1'b0;

    vecs[5].n = 5'd16; vecs[5].use_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vecs[5].a[i] = 8'd1; vecs[5].b[i] = 8'd1;
    end
    vecs[5].exp_result = 20'd16; vecs[5].exp_count = 5'd16; vecs[5].exp_trunc = 1'b0;

    rst_vec = '0;
    rst_vec.n = 5'd1; rst_vec.use_last = 1'b1;
    rst_vec.a[0] = 8'd2; rst_vec.b[0] = 8'd2;
    rst_vec.exp_result = 20'd4; rst_vec.exp_count = 5'd1; rst_vec.exp_trunc = 1'b0;

    // Power-on reset and idle-state checks.
    resetn      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge UserCLK);
    #1;
    checkOutput("reset.s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("reset.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("reset.mac_clr", 32'(mac_clr), 32'd0);
    checkOutput("reset.mac_A", 32'(mac_A), 32'd0);
    checkOutput("reset.mac_B", 32'(mac_B), 32'd0);
    checkOutput("reset.mac_C", 32'(mac_C), 32'd0);
    checkOutput("reset.m_result", 32'(bus.m_result), 32'd0);
    resetn = 1'b1;
    @(posedge UserCLK);
    #1;

    // Table-driven vectors, run back to back.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset in the middle of a four-pair vector after two accepts.
    send_pair(8'd1, 8'd2, 1'b0, dummy_edge);
    send_pair(8'd3, 8'd4, 1'b0, dummy_edge);
    bus.s_valid = 1'b0;
    resetn      = 1'b0;
    @(posedge UserCLK);
    #1;
    resetn = 1'b1;
    checkOutput("midreset.s_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("midreset.m_valid", 32'(bus.m_valid), 32'd0);
    checkOutput("midreset.mac_A", 32'(mac_A), 32'd0);
    checkOutput("midreset.mac_B", 32'(mac_B), 32'd0);
    checkOutput("midreset.mac_clr", 32'(mac_clr), 32'd0);
    checkOutput("midreset.m_result", 32'(bus.m_result), 32'd0);
    checkOutput("midreset.m_count", 32'(bus.m_count), 32'd0);
    checkOutput("midreset.m_trunc", 32'(bus.m_trunc), 32'd0);
    @(posedge UserCLK);
    #1;
    applyStimulus(rst_vec, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/muladd_seq.md
# muladd_seq

Sequencer that drives one MULADD DSP BEL as a dot-product engine. It accepts a stream of 8-bit operand pairs over a valid/ready handshake, clears the MULADD accumulator, feeds the pairs, waits out the accumulator latency, and returns the 20-bit sum on a second valid/ready handshake. It sits in the fabric between a user data source and the MULADD A/B/C/clr/Q pins.

## Interface
Parameters:
- MAX_LEN, 16: maximum pairs per vector. 16 × 255 × 255 = 1,040,400 fits in 20 bits, so an accumulation can never overflow.
- CNT_W, 5: width of the pair counter; must satisfy 2^CNT_W > MAX_LEN.

Ports:
- UserCLK  in  1: single clock, shared with the driven MULADD.
- resetn  in  1: reset, synchronous and active-low.
- s_valid  in  1: an operand pair is offered.
- s_ready  out  1: the pair is accepted on an edge where s_valid && s_ready.
- s_a  in  8: operand A, unsigned.
- s_b  in  8: operand B, unsigned.
- s_last  in  1: marks the final pair of the vector.
- mac_A  out  8: to MULADD A.
- mac_B  out  8: to MULADD B.
- mac_C  out  20: to MULADD C; constant 0.
- mac_clr  out  1: to MULADD clr.
- mac_Q  in  20: from MULADD Q.
- m_valid  out  1: result available.
- m_ready  in  1: the result is consumed on an edge where m_valid && m_ready.
- m_result  out  20: dot-product sum.
- m_count  out  CNT_W: number of pairs accumulated.
- m_trunc  out  1: the vector was cut at MAX_LEN without s_last.

## Operation
The MULADD must be configured as A_reg=0, B_reg=0, C_reg=0, ACC=1, signExtension=0, ACCout=1. In this mode:
- Q equals the ACC register.
- On each edge, ACC <= A×B + ACC, or ACC <= 0 when clr is high.

The accumulator adds every cycle, so mac_A and mac_B must be 0 whenever no pair is being fed.

State machine:
- IDLE: s_ready=0, m_valid=0. If s_valid, go to CLEAR.
- CLEAR: one cycle. mac_clr=1, mac_A=mac_B=0, count<=0. Go to ACCUM.
- ACCUM: s_ready=1. On an accept:
  - mac_A<=s_a, mac_B<=s_b, count<=count+1.
  - If s_last, or count+1==MAX_LEN, go to FLUSH.
  - m_trunc<=(count+1==MAX_LEN) && !s_last.
  - On a non-accept cycle, mac_A<=0 and mac_B<=0.
- FLUSH: one cycle. s_ready=0. mac_A/mac_B still hold the last pair, so ACC absorbs it on this edge. mac_A<=0, mac_B<=0. Go to CAPTURE.
- CAPTURE: one cycle. mac_Q now includes every pair. m_result<=mac_Q, m_count<=count. Go to DONE.
- DONE: m_valid=1. m_result, m_count and m_trunc are held stable. On m_valid && m_ready, go to IDLE.

Other rules:
- mac_A, mac_B and mac_clr are registered outputs (all except mac_C, which is tied to 0).
- Arithmetic is unsigned. No saturation is needed because MAX_LEN bounds the sum.
- A pair with s_last=1 and count==MAX_LEN-1 gives m_trunc=0.
- Reset (resetn low at an edge), from any state including mid-ACCUM or DONE:
  - state<=IDLE, s_ready=0, m_valid=0.
  - mac_A=mac_B=0, mac_clr=0.
  - m_result=0, m_count=0, m_trunc=0.
  - A pending result is discarded. The next vector is cleared in CLEAR.

## Timing
- First pair is accepted no earlier than the second edge after s_valid is seen in IDLE (IDLE→CLEAR→ACCUM).
- A pair accepted at edge e is on mac_A/B during cycle e..e+1 and is in ACC after edge e+1.
- From the last accept at edge t:
  - FLUSH spans t..t+1.
  - CAPTURE spans t+1..t+2.
  - m_valid rises after edge t+2.
- Throughput in ACCUM: one pair per cycle. Gaps in s_valid insert zero products.
- Per-vector overhead: IDLE + CLEAR + FLUSH + CAPTURE + at least one DONE cycle = 5 cycles.
- s_ready is 0 in every state except ACCUM. Upstream must hold s_a, s_b and s_last stable while s_valid && !s_ready.
- m_valid stays high until accepted. The DONE→IDLE transition takes one edge, so back-to-back vectors need no bubble beyond the overhead above.

## Test plan
- Basic: pairs (3,4), (5,6), (7,8) with s_last on the third, m_ready=1 → m_result=98, m_count=3, m_trunc=0; m_valid rises 2 edges after the third accept.
- Truncation: 16 pairs of (255,255), s_last never asserted → m_result=0xFE010 (1,040,400), m_count=16, m_trunc=1, s_ready=0 after the 16th accept.
- Bubbles and backpressure: pairs (10,10), gap of 3 cycles, (2,3) with s_last, m_ready low for 5 cycles → m_result=106 held stable across the wait, with exactly one handshake.
- Single pair: (0,9) with s_last, then immediately (1,1) with s_last → results 0 then 1. The second run proves CLEAR zeroed the ACC left holding the previous result.
- Reset mid-operation: resetn low for one edge after 2 of 4 pairs → all outputs 0, state IDLE. A following vector (2,2) with s_last gives 4, not a carried-over sum.
- Exact limit: 16 pairs (1,1) with s_last on the 16th → m_result=16, m_count=16, m_trunc=0.
